// File: rtl/feature_stream_out_pkg.sv
// Shared constants and FSM state encoding for feature_stream_out.
package feature_stream_out_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_IN     = 100;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/feature_stream_out.sv
// Captures one packed feature vector and streams its elements one per accepted beat.
// Optional macro FEATURE_STREAM_OUT_RELU_EN clamps negative elements to zero on the output path.
module feature_stream_out
  import feature_stream_out_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int numofinput = NUM_IN,
  localparam int IDX_W     = (numofinput > 1) ? $clog2(numofinput) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [numofinput*data_width-1:0]   f_in,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic signed [data_width-1:0]       out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic [IDX_W-1:0]                   out_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numofinput - 1);

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [numofinput*data_width-1:0] vec_q, vec_d;
  logic [data_width-1:0]            elem;
  logic                             at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end

  assign at_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          vec_d   = f_in;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // idx returns to 0 on the last beat so it never exceeds numofinput-1
          if (at_last) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    elem     = vec_q[int'(idx_q) * data_width +: data_width];
    out_data = '0;
    out_last = 1'b0;
    out_idx  = idx_q;
    if (state_q == STREAM) begin
`ifdef FEATURE_STREAM_OUT_RELU_EN
      out_data = elem[data_width-1] ? '0 : elem;
`else
      out_data = elem;
`endif
      out_last = at_last;
    end
  end

endmodule

// File: tb/tb_feature_stream_out.sv
// Directed self-checking bench for feature_stream_out (default 16-bit x 100 configuration).
module tb_feature_stream_out;

  localparam int DW = 16;
  localparam int N  = 100;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N*DW-1:0]      f_in;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [6:0]           out_idx;

  logic [DW-1:0] cap [N];
  int n_assert = 0;
  int n_fail   = 0;

  feature_stream_out #(.data_width(DW), .numofinput(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_in      (f_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] x);
`ifdef FEATURE_STREAM_OUT_RELU_EN
    return x[DW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // kind 0: element i = i; kind 1: as 0 with elements 5/6 at the signed extremes; kind 2: all ones
  task automatic fill(input int kind);
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] v;
      v = (kind == 2) ? 16'hFFFF : DW'(i);
      if (kind == 1 && i == 5) v = 16'h8000;
      if (kind == 1 && i == 6) v = 16'h7FFF;
      f_in[i*DW +: DW] = v;
    end
  endtask

  task automatic expect_captured();
    for (int i = 0; i < N; i++) cap[i] = f_in[i*DW +: DW];
  endtask

  task automatic beat_chk(input int i);
    chk($sformatf("valid[%0d]", i), 32'(out_valid), 32'd1);
    chk($sformatf("idx[%0d]", i),   32'(out_idx), 32'(i));
    chk($sformatf("data[%0d]", i),  32'(out_data[DW-1:0]), 32'(model(cap[i])));
    chk($sformatf("last[%0d]", i),  32'(out_last), 32'(i == N - 1));
    chk($sformatf("in_ready_stream[%0d]", i), 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; f_in = '0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_data", 32'(out_data[DW-1:0]), 32'd0);

    // Ramp vector, out_ready held high: 100 back-to-back beats
    rst_n = 1'b1; fill(0); expect_captured(); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      beat_chk(i);
      step();
    end
    chk("ramp_done_in_ready", 32'(in_ready), 32'd1);
    chk("ramp_done_out_valid", 32'(out_valid), 32'd0);

    // Signed extremes at elements 5 and 6
    fill(1); expect_captured(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      beat_chk(i);
      if (i == 5) chk("elem5_extreme", 32'(out_data[DW-1:0]), model(16'h8000) == 16'h8000 ? 32'h8000 : 32'h0);
      if (i == 6) chk("elem6_extreme", 32'(out_data[DW-1:0]), 32'h7FFF);
      step();
    end

    // Backpressure at beat 3, input overwritten mid-stream, then back-to-back capture
    fill(0); expect_captured(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat_chk(i);
      step();
    end
    out_ready = 1'b0;
    fill(2); in_valid = 1'b1;
    beat_chk(3); step();
    beat_chk(3); step();
    out_ready = 1'b1;
    beat_chk(3); step();
    chk("after_stall_data", 32'(out_data[DW-1:0]), 32'd4);
    for (int i = 4; i < N; i++) begin
      beat_chk(i);
      step();
    end
    chk("gap_in_ready", 32'(in_ready), 32'd1);
    chk("gap_out_valid", 32'(out_valid), 32'd0);
    expect_captured();
    step();
    for (int i = 0; i < 50; i++) begin
      beat_chk(i);
      step();
    end

    // Reset in the middle of vector B at beat 50
    beat_chk(50);
    rst_n = 1'b0; fill(0);
    step();
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_idx", 32'(out_idx), 32'd0);
    chk("midrst_out_data", 32'(out_data[DW-1:0]), 32'd0);
    expect_captured();
    step();
    in_valid = 1'b0;
    beat_chk(0); step();
    beat_chk(1); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/feature_stream_out.md
FEATURE_STREAM_OUT -- requirements
Module: feature_stream_out

Interface
REQ-001 The block SHALL expose parameter data_width, default 16, as the signed element width in bits.
REQ-002 The block SHALL expose parameter numofinput, default 100, as the number of elements per packed feature vector.
REQ-003 The block SHALL have port clk  input  1  as its single clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  as a synchronous, active-low reset.
REQ-005 The block SHALL have port f_in  input  numofinput*data_width  as the packed summed feature vector, with element i at bits [i*data_width +: data_width].
REQ-006 The block SHALL have port in_valid  input  1  to mark f_in as valid.
REQ-007 The block SHALL have port in_ready  output  1  to signal that a vector can be captured.
REQ-008 The block SHALL have port out_data  output  data_width  as the signed streamed element.
REQ-009 The block SHALL have port out_valid  output  1  to mark out_data as valid.
REQ-010 The block SHALL have port out_ready  input  1  as downstream acceptance.
REQ-011 The block SHALL have port out_last  output  1  to mark element numofinput-1.
REQ-012 The block SHALL have port out_idx  output  clog2(numofinput)  as the index of the current element.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and STREAM.
REQ-014 In IDLE: in_ready=1, out_valid=0; when in_valid=1, the block SHALL register all of f_in, set idx=0 and enter STREAM on the next edge.
REQ-015 In STREAM: in_ready=0, out_valid=1, out_data=element[idx], out_idx=idx, out_last=(idx==numofinput-1).
REQ-016 A beat transfers only when out_valid&&out_ready; idx SHALL then increment by 1.
REQ-017 When out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-018 The transfer with out_last=1 SHALL return the FSM to IDLE, giving one IDLE cycle between vectors; idx never wraps beyond numofinput-1.
REQ-019 Changes on f_in or in_valid during STREAM SHALL be ignored; the captured vector is immutable until the last beat.
REQ-020 Capture latency SHALL be one cycle: the first element is valid in the cycle after the in_valid&&in_ready edge.
REQ-021 out_data SHALL be exactly data_width bits, with no width growth; with RELU_EN undefined it SHALL equal the captured element bit-for-bit.

Reset
REQ-022 While rst_n=0 at a clock edge, the block SHALL go to IDLE, idx=0, out_valid=0, out_last=0, out_idx=0, out_data=0, in_ready=1 from the following cycle.
REQ-023 Reset asserted mid-STREAM SHALL abandon the current vector with no further beats.

Configuration
REQ-024 When macro FEATURE_STREAM_OUT_RELU_EN is defined, out_data SHALL be 0 for any element whose sign bit is 1, and the element unchanged otherwise; the ReLU SHALL be applied on the output path, adding no latency.
REQ-025 When FEATURE_STREAM_OUT_RELU_EN is undefined, no ReLU logic SHALL be present.

Structure
REQ-026 The shared package SHALL hold DATA_WIDTH=16, NUM_IN=100 and the state encoding (IDLE=0, STREAM=1).
REQ-027 The block SHALL be flat, with no sub-modules; the element mux and the optional ReLU are inline.

Verification
REQ-028 Elements 0..99 = 0,1,..,99 with out_ready held at 1 -> 100 consecutive beats, out_data=i, out_last only at i=99, in_ready=1 the cycle after.
REQ-029 Element 5 = 16'h8000 (-32768) and element 6 = 16'h7FFF -> streamed unchanged without RELU_EN; 0 and 32767 with RELU_EN.
REQ-030 out_ready toggling 1,0,0,1 from beat 3 -> out_data=3 held for 3 cycles, then 4; no beat lost or duplicated.
REQ-031 f_in changed to all 16'hFFFF with in_valid=1 during STREAM -> streamed values remain the originally captured vector.
REQ-032 rst_n=0 for one edge at beat 50 -> next cycle out_valid=0 and in_ready=1; a new vector then starts at out_idx=0.
REQ-033 Two vectors offered back-to-back with in_valid held at 1 -> exactly one IDLE cycle between out_last of vector A and beat 0 of vector B.
